uart_term_tx: RTL and testbench

- Serial-line end of the terminal UART. Takes bytes from the TXDATA path (CPU MMIO writes) and buffers them in a small FIFO.
- Drives them onto a single 8N1 serial output at a fixed bit period.
- Sits between the UART MMIO register block and the board/testbench TX pin. Backpressure is exposed through o_ready so the register block can report TX-full in its status word.

---
 rtl/uart_term_tx.sv | 147 ++++++++++++++
 tb/tb_uart_term_tx.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_term_tx.sv
// 8N1 serial transmitter for the terminal UART: a small byte FIFO feeding a
// start/data/stop shift FSM that drives a registered, idle-high TX line.
module uart_term_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [7:0]                  i_data,
  input  logic                        i_valid,
  output logic                        o_ready,
  output logic                        o_tx,
  output logic                        o_busy,
  output logic [$clog2(FIFO_DEPTH):0] o_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_RELOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [PW:0]   DEPTH_C     = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [7:0]    mem [FIFO_DEPTH];

  logic push;
  logic pop;
  logic fifo_empty;

  assign o_ready    = (count_q < DEPTH_C);
  assign push       = i_valid && o_ready;
  assign fifo_empty = (count_q == '0);

  assign o_tx    = tx_q;
  assign o_busy  = (state_q != IDLE) || (count_q != '0);
  assign o_count = count_q;

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr_q];
          baud_d  = BAUD_RELOAD;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (baud_q != '0) begin
          baud_d = baud_q - 1'b1;
        end else begin
          tx_d      = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = '0;
          baud_d    = BAUD_RELOAD;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (baud_q != '0) begin
          baud_d = baud_q - 1'b1;
        end else if (bit_idx_q != 3'd7) begin
          tx_d      = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          baud_d    = BAUD_RELOAD;
        end else begin
          tx_d    = 1'b1;
          baud_d  = BAUD_RELOAD;
          state_d = STOP;
        end
      end
      STOP: begin
        if (baud_q != '0) begin
          baud_d = baud_q - 1'b1;
        end else if (!fifo_empty) begin
          // Chain straight into the next start bit with no idle gap.
          pop     = 1'b1;
          shift_d = mem[rd_ptr_q];
          tx_d    = 1'b0;
          baud_d  = BAUD_RELOAD;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // Storage is left unreset; occupancy and pointers alone define validity.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr_q] <= i_data;
  end

endmodule

// File: tb/tb_uart_term_tx.sv
// Bench for uart_term_tx: frame-table vectors, directed corner sequences and
// random traffic checked each cycle against a frame-timeline reference model.
module tb_uart_term_tx;

  localparam int C = 4;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic       i_valid = 1'b0;
  logic       o_ready, o_tx, o_busy;
  logic [2:0] o_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  uart_term_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(i_data), .i_valid(i_valid),
    .o_ready(o_ready), .o_tx(o_tx), .o_busy(o_busy), .o_count(o_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: a queue of waiting bytes plus a single frame timer that
  // runs 10*C cycles per byte and immediately takes the next queued byte.
  logic [7:0] m_q[$];
  logic [7:0] exp_rx[$];
  bit         m_active = 0;
  logic [7:0] m_cur = 8'h00;
  int         m_t = 0;
  bit         m_push = 0;
  bit         m_pop;
  int         m_sz;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      exp_rx.delete();
      m_active = 0;
      m_t = 0;
      m_push = 0;
    end else begin
      m_sz = m_q.size();
      m_pop = 0;
      if (!m_active) m_pop = (m_sz > 0);
      else if (m_t == 10 * C - 1) begin
        if (m_sz > 0) m_pop = 1;
        else m_active = 0;
      end else m_t++;
      m_push = i_valid && (m_sz < D);
      if (m_pop) begin
        m_cur = m_q.pop_front();
        m_active = 1;
        m_t = 0;
        exp_rx.push_back(m_cur);
      end
      if (m_push) m_q.push_back(i_data);
    end
  end

  function automatic int exp_tx();
    int k;
    if (!m_active) return 1;
    k = m_t / C;
    if (k == 0) return 0;
    if (k <= 8) return int'(m_cur[k-1]);
    return 1;
  endfunction

  always @(negedge clk) begin
    chk("tx", int'(o_tx), exp_tx());
    chk("count", int'(o_count), m_q.size());
    chk("ready", int'(o_ready), int'(m_q.size() < D));
    chk("busy", int'(o_busy), int'(m_active || (m_q.size() != 0)));
  end

  // Serial decoder: samples the line mid-bit and checks each frame's byte.
  logic [7:0] rx_log[$];
  int         start_cyc[$];
  bit         rx_active = 0;
  int         rx_t = 0;
  int         rx_k;
  logic [7:0] rx_b = 8'h00;

  always @(negedge clk) begin
    if (!rst_n) begin
      rx_active = 0;
    end else if (!rx_active) begin
      if (o_tx == 1'b0) begin
        rx_active = 1;
        rx_t = 0;
        start_cyc.push_back(cyc);
      end
    end else begin
      rx_t++;
      if (rx_t % C == C / 2) begin
        rx_k = rx_t / C;
        if (rx_k == 0) chk("rx_start", int'(o_tx), 0);
        else if (rx_k <= 8) rx_b[rx_k-1] = o_tx;
        else begin
          chk("rx_stop", int'(o_tx), 1);
          if (exp_rx.size() == 0) chk("rx_extra_frame", 1, 0);
          else chk("rx_byte", int'(rx_b), int'(exp_rx.pop_front()));
          rx_log.push_back(rx_b);
          rx_active = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    i_valid = 1'b1;
    i_data  = b;
    tick();
    i_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_active || m_q.size() != 0) && n < 3000) begin
      tick();
      n++;
    end
    chk("drain_timeout", int'(n >= 3000), 0);
    repeat (3) tick();
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;

  vec_t vecs[6];
  logic [7:0] seq_bytes[4];
  int idx;
  int n;
  int rate;

  initial begin
    vecs[0] = '{8'hA5, 10'b1101001010};
    vecs[1] = '{8'h00, 10'b1000000000};
    vecs[2] = '{8'hFF, 10'b1111111110};
    vecs[3] = '{8'h3C, 10'b1001111000};
    vecs[4] = '{8'h81, 10'b1100000010};
    vecs[5] = '{8'h6E, 10'b1011011100};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("idle_tx", int'(o_tx), 1);
      chk("idle_ready", int'(o_ready), 1);
      chk("idle_busy", int'(o_busy), 0);
      chk("idle_count", int'(o_count), 0);
    end

    // Frame table: line value mid-bit and exact busy drop 40 cycles after pop
    for (int v = 0; v < 6; v++) begin
      push(vecs[v].data);
      tick();
      for (int k = 0; k < 10; k++) begin
        repeat (C / 2) tick();
        chk($sformatf("frame%0d_bit%0d", v, k), int'(o_tx), int'(vecs[v].frame[k]));
        if (k < 9) repeat (C - C / 2) tick();
        else repeat (C - C / 2 - 1) tick();
      end
      chk("busy_before_end", int'(o_busy), 1);
      tick();
      chk("busy_after_end", int'(o_busy), 0);
      repeat (5) tick();
    end

    // Back-to-back frames
    rx_log.delete();
    start_cyc.delete();
    push(8'h55);
    push(8'h0F);
    wait_idle();
    chk("b2b_frames", start_cyc.size(), 2);
    if (start_cyc.size() == 2) chk("b2b_spacing", start_cyc[1] - start_cyc[0], 10 * C);
    if (rx_log.size() == 2) begin
      chk("b2b_byte0", int'(rx_log[0]), 8'h55);
      chk("b2b_byte1", int'(rx_log[1]), 8'h0F);
    end

    // FIFO full with valid held high; excess bytes held off
    rx_log.delete();
    idx = 1;
    n = 0;
    while (idx <= 6 && n < 400) begin
      i_valid = 1'b1;
      i_data  = 8'(idx);
      tick();
      n++;
      if (m_push) idx++;
      if (n == 5) begin
        chk("full_count", int'(o_count), 4);
        chk("full_ready", int'(o_ready), 0);
      end
    end
    i_valid = 1'b0;
    chk("full_push_timeout", int'(n >= 400), 0);
    wait_idle();
    chk("full_frames", rx_log.size(), 6);
    for (int i = 0; i < 6 && i < rx_log.size(); i++)
      chk($sformatf("full_order%0d", i), int'(rx_log[i]), i + 1);

    // Asynchronous reset in the middle of data bit 3 of 0x00
    push(8'h00);
    push(8'hFF);
    repeat (17) tick();
    chk("pre_reset_bit3", int'(o_tx), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_tx", int'(o_tx), 1);
    chk("async_rst_count", int'(o_count), 0);
    chk("async_rst_busy", int'(o_busy), 0);
    chk("async_rst_ready", int'(o_ready), 1);
    @(negedge clk);
    repeat (3) tick();
    rst_n = 1'b1;
    rx_log.delete();
    for (int i = 0; i < 60; i++) begin
      tick();
      chk("post_rst_idle", int'(o_tx), 1);
    end
    chk("post_rst_frames", rx_log.size(), 0);

    // Push coinciding with the STOP-end pop while two bytes are queued
    rx_log.delete();
    seq_bytes[0] = 8'hA1;
    seq_bytes[1] = 8'hB2;
    seq_bytes[2] = 8'hC3;
    seq_bytes[3] = 8'hD4;
    push(seq_bytes[0]);
    push(seq_bytes[1]);
    push(seq_bytes[2]);
    repeat (10 * C - 2) tick();
    chk("pp_count_before", int'(o_count), 2);
    push(seq_bytes[3]);
    chk("pp_count_after", int'(o_count), 2);
    chk("pp_next_start", int'(o_tx), 0);
    wait_idle();
    chk("pp_frames", rx_log.size(), 4);
    for (int i = 0; i < 4 && i < rx_log.size(); i++)
      chk($sformatf("pp_order%0d", i), int'(rx_log[i]), int'(seq_bytes[i]));

    // Random traffic at several offered loads
    for (int ph = 0; ph < 4; ph++) begin
      rate = (ph == 0) ? 5 : (ph == 1) ? 40 : (ph == 2) ? 100 : 2;
      for (int i = 0; i < 1000; i++) begin
        i_valid = ($urandom_range(0, 99) < rate);
        i_data  = 8'($urandom);
        tick();
      end
    end
    i_valid = 1'b0;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
